// File: rtl/ofm_addr_controller_pkg.sv
// Shared constants and helpers for OFM write-address generation.
// Geometry is parameter-dependent, so derived values are exposed as constant functions.
package ofm_addr_controller_pkg;

  localparam int unsigned DEF_ADDR_WIDTH    = 22;
  localparam int unsigned DEF_SYSTOLIC_SIZE = 16;
  localparam int unsigned DEF_OFM_SIZE      = 32;
  localparam int unsigned FILTER_W          = 7;
  localparam int unsigned SIZE_W            = 5;

  // Number of column blocks needed to cover one OFM row.
  function automatic int unsigned calc_nblk(input int unsigned ofm, input int unsigned sys);
    return (ofm + sys - 1) / sys;
  endfunction

  function automatic int unsigned calc_map_words(input int unsigned ofm);
    return ofm * ofm;
  endfunction

  // Counter width that never collapses to zero bits for single-value ranges.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Valid width of a segment; the last block may be partial.
  function automatic int unsigned min_size(input int unsigned blk, input int unsigned ofm,
                                           input int unsigned sys);
    int unsigned rem;
    rem = ofm - blk * sys;
    return (rem < sys) ? rem : sys;
  endfunction

endpackage

// File: rtl/ofm_addr_controller_pos_counter.sv
// Row/column-block position walker: rows of block 0 first, then block 1, wrapping to (0,0).
// clear forces the effective position to (0,0) in the same cycle it is asserted.
module ofm_pos_counter
  import ofm_addr_controller_pkg::*;
#(
  parameter int unsigned OFM_SIZE      = DEF_OFM_SIZE,
  parameter int unsigned SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
  parameter int unsigned NBLK          = calc_nblk(OFM_SIZE, SYSTOLIC_SIZE),
  parameter int unsigned ROW_W         = cnt_w(OFM_SIZE),
  parameter int unsigned BLK_W         = cnt_w(NBLK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic             clear,
  output logic [ROW_W-1:0] erow_c,
  output logic [BLK_W-1:0] eblk_c
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OFM_SIZE - 1);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NBLK - 1);

  logic [ROW_W-1:0] row, row_nxt;
  logic [BLK_W-1:0] blk, blk_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      blk <= '0;
    end else begin
      row <= row_nxt;
      blk <= blk_nxt;
    end
  end

  // Effective position and next-state; write consumes the effective position.
  always_comb begin
    erow_c  = clear ? '0 : row;
    eblk_c  = clear ? '0 : blk;
    row_nxt = erow_c;
    blk_nxt = eblk_c;
    if (write) begin
      if (erow_c == LAST_ROW) begin
        row_nxt = '0;
        blk_nxt = (eblk_c == LAST_BLK) ? '0 : eblk_c + BLK_W'(1);
      end else begin
        row_nxt = erow_c + ROW_W'(1);
      end
    end
  end

endmodule

// File: rtl/ofm_addr_controller.sv
// OFM write-address generator: segment start address and valid width for the current position.
// Outputs are combinational so a filter change is visible in the same cycle.
module ofm_addr_controller
  import ofm_addr_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
  parameter int unsigned OFM_SIZE      = DEF_OFM_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write,
  input  logic [FILTER_W-1:0]   count_filter,
  output logic [ADDR_WIDTH-1:0] ofm_addr,
  output logic [SIZE_W-1:0]     size
);

  localparam int unsigned NBLK      = calc_nblk(OFM_SIZE, SYSTOLIC_SIZE);
  localparam int unsigned MAP_WORDS = calc_map_words(OFM_SIZE);
  localparam int unsigned ROW_W     = cnt_w(OFM_SIZE);
  localparam int unsigned BLK_W     = cnt_w(NBLK);

  logic [FILTER_W-1:0] prev_filter;
  logic                chg_c;
  logic [ROW_W-1:0]    erow_c;
  logic [BLK_W-1:0]    eblk_c;

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) prev_filter <= '0;
    else       prev_filter <= count_filter;
  end

  assign chg_c = (count_filter != prev_filter);

  ofm_pos_counter #(
    .OFM_SIZE      (OFM_SIZE),
    .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
    .NBLK          (NBLK),
    .ROW_W         (ROW_W),
    .BLK_W         (BLK_W)
  ) u_pos (
    .clk    (clk),
    .rst    (rst_n),
    .write  (write),
    .clear  (chg_c),
    .erow_c (erow_c),
    .eblk_c (eblk_c)
  );

  // All terms wrap modulo 2^ADDR_WIDTH; multipliers are constants.
  always_comb begin
    ofm_addr = ADDR_WIDTH'(count_filter) * ADDR_WIDTH'(MAP_WORDS)
             + ADDR_WIDTH'(erow_c) * ADDR_WIDTH'(OFM_SIZE)
             + ADDR_WIDTH'(eblk_c) * ADDR_WIDTH'(SYSTOLIC_SIZE);
    size     = SIZE_W'(min_size(32'(eblk_c), OFM_SIZE, SYSTOLIC_SIZE));
  end

endmodule

// File: tb/tb_ofm_addr_controller.sv
// Scoreboard bench for ofm_addr_controller: default geometry plus a 13x13 single-block instance.
module tb_ofm_addr_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr, wr13;
  logic [6:0] cf, cf13;
  logic [21:0] addr, addr13;
  logic [4:0]  sz, sz13;

  typedef struct {
    string       name;
    logic [21:0] addr;
    logic [4:0]  size;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ofm_addr_controller dut (
    .clk(clk), .rst_n(rst_n), .write(wr), .count_filter(cf), .ofm_addr(addr), .size(sz)
  );

  ofm_addr_controller #(.ADDR_WIDTH(22), .SYSTOLIC_SIZE(16), .OFM_SIZE(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .write(wr13), .count_filter(cf13), .ofm_addr(addr13), .size(sz13)
  );

  task automatic test_reset();
    q.push_back('{"reset_def", 22'd0, 5'd16});
    q.push_back('{"reset_13", 22'd0, 5'd13});
    #1;
    e = q.pop_front(); checks++;
    if (addr !== e.addr || sz !== e.size) begin
      errors++;
      $display("FAIL %s: got addr=%0d size=%0d expected addr=%0d size=%0d", e.name, addr, sz, e.addr, e.size);
    end
    e = q.pop_front(); checks++;
    if (addr13 !== e.addr || sz13 !== e.size) begin
      errors++;
      $display("FAIL %s: got addr=%0d size=%0d expected addr=%0d size=%0d", e.name, addr13, sz13, e.addr, e.size);
    end
    @(negedge clk); rst_n = 1'b0;
    q.push_back('{"release", 22'd0, 5'd16});
    #1;
    e = q.pop_front(); checks++;
    if (addr !== e.addr || sz !== e.size) begin
      errors++;
      $display("FAIL %s: got addr=%0d size=%0d expected addr=%0d size=%0d", e.name, addr, sz, e.addr, e.size);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); wr = (k < 3);
      q.push_back('{$sformatf("prewalk_%0d", k), 22'(32 * k), 5'd16});
      #1;
      e = q.pop_front(); checks++;
      if (addr !== e.addr || sz !== e.size) begin
        errors++;
        $display("FAIL %s: got addr=%0d size=%0d expected addr=%0d size=%0d", e.name, addr, sz, e.addr, e.size);
      end
    end
    // Reset between clock edges must clear immediately.
    #2 rst_n = 1'b1;
    q.push_back('{"async_reset", 22'd0, 5'd16});
    #1;
    e = q.pop_front(); checks++;
    if (addr !== e.addr || sz !== e.size) begin
      errors++;
      $display("FAIL %s: got addr=%0d size=%0d expected addr=%0d size=%0d", e.name, addr, sz, e.addr, e.size);
    end
    @(negedge clk); rst_n = 1'b0;
  endtask

  task automatic test_filter0_walk();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); wr = (k < 5);
      q.push_back('{$sformatf("f0_walk_%0d", k), 22'(32 * k), 5'd16});
      #1;
      e = q.pop_front(); checks++;
      if (addr !== e.addr || sz !== e.size) begin
        errors++;
        $display("FAIL %s: got addr=%0d size=%0d expected addr=%0d size=%0d", e.name, addr, sz, e.addr, e.size);
      end
    end
  endtask

  task automatic test_filter_change_idle();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cf = 7'd1;
      wr = (k >= 2 && k < 7);
      q.push_back('{$sformatf("f1_idle_%0d", k), 22'(1024 + 32 * ((k < 2) ? 0 : k - 2)), 5'd16});
      #1;
      e = q.pop_front(); checks++;
      if (addr !== e.addr || sz !== e.size) begin
        errors++;
        $display("FAIL %s: got addr=%0d size=%0d expected addr=%0d size=%0d", e.name, addr, sz, e.addr, e.size);
      end
    end
  endtask

  task automatic test_full_map();
    // Reset clears prev_filter, so filter 1 registers as a change and restarts at (0,0).
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk); wr = (k < 64);
      q.push_back('{$sformatf("map_%0d", k),
                    22'(1024 + 32 * ((k % 64) % 32) + 16 * ((k % 64) / 32)), 5'd16});
      #1;
      e = q.pop_front(); checks++;
      if (addr !== e.addr || sz !== e.size) begin
        errors++;
        $display("FAIL %s: got addr=%0d size=%0d expected addr=%0d size=%0d", e.name, addr, sz, e.addr, e.size);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      wr = (k < 11);
      cf = (k < 10) ? 7'd1 : 7'd2;
      if (k < 10)       q.push_back('{$sformatf("b2b_%0d", k), 22'(1024 + 32 * k), 5'd16});
      else if (k == 10) q.push_back('{"b2b_change", 22'd2048, 5'd16});
      else              q.push_back('{"b2b_after", 22'd2080, 5'd16});
      #1;
      e = q.pop_front(); checks++;
      if (addr !== e.addr || sz !== e.size) begin
        errors++;
        $display("FAIL %s: got addr=%0d size=%0d expected addr=%0d size=%0d", e.name, addr, sz, e.addr, e.size);
      end
    end
    wr = 1'b0;
  endtask

  task automatic test_partial_block();
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      cf13 = 7'd3;
      wr13 = (k < 13);
      q.push_back('{$sformatf("p13_%0d", k), 22'(507 + 13 * (k % 13)), 5'd13});
      #1;
      e = q.pop_front(); checks++;
      if (addr13 !== e.addr || sz13 !== e.size) begin
        errors++;
        $display("FAIL %s: got addr=%0d size=%0d expected addr=%0d size=%0d", e.name, addr13, sz13, e.addr, e.size);
      end
    end
    wr13 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    wr = 1'b0; wr13 = 1'b0;
    cf = 7'd0; cf13 = 7'd0;
    test_reset();
    test_filter0_walk();
    test_filter_change_idle();
    test_full_map();
    test_back_to_back();
    test_partial_block();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofm_addr_controller.md
Name: ofm_addr_controller

Overview:
- Generates output-feature-map (OFM) write addresses for systolic-array results.
- The OFM of each filter is stored row-major, OFM_SIZE x OFM_SIZE words, at base count_filter*OFM_SIZE*OFM_SIZE.
- Results leave the array as row segments up to SYSTOLIC_SIZE wide. The block walks the map one segment per write cycle and reports the segment start address and its valid width.

Parameters:
- ADDR_WIDTH, 22: width of ofm_addr. All address arithmetic is truncated modulo 2^ADDR_WIDTH.
- SYSTOLIC_SIZE, 16: maximum segment width. Legal range 1..31.
- OFM_SIZE, 32: OFM height and width in words. Must be >= 1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset, asynchronous, active-high. Asserted when 1, despite the name.
- write, input, 1: the current segment is consumed at this clock edge; advance the position.
- count_filter, input, 7: current filter index; selects the map base.
- ofm_addr, output, ADDR_WIDTH: start address of the current segment.
- size, output, 5: number of valid words in the current segment.

Behaviour:
- State registers:
  - row, 0..OFM_SIZE-1.
  - blk, 0..NBLK-1, where NBLK = ceil(OFM_SIZE/SYSTOLIC_SIZE).
  - prev_filter, 7 bits.
- Reset (rst_n=1, asynchronous): row=0, blk=0, prev_filter=0.
- Change detect: chg = (count_filter != prev_filter), combinational.
- Effective position: (erow, eblk) = chg ? (0,0) : (row, blk).
- Outputs (combinational, no added latency):
  - ofm_addr = count_filter*OFM_SIZE*OFM_SIZE + erow*OFM_SIZE + eblk*SYSTOLIC_SIZE.
  - size = min(SYSTOLIC_SIZE, OFM_SIZE - eblk*SYSTOLIC_SIZE).
- Output values during reset, with count_filter=0: ofm_addr=0, size=min(SYSTOLIC_SIZE,OFM_SIZE).
- Every rising edge with rst_n=0:
  - prev_filter <= count_filter.
  - write=0: row <= erow, blk <= eblk. This holds the position, or clears it to 0 if chg.
  - write=1 and erow < OFM_SIZE-1: row <= erow+1, blk <= eblk.
  - write=1 and erow = OFM_SIZE-1: row <= 0; blk <= eblk+1, wrapping to 0 after NBLK-1.
- Walk order: all rows of column block 0, then all rows of block 1, and so on. The map is complete after OFM_SIZE*NBLK writes and then wraps to position (0,0) of the same filter.
- count_filter change with write=1 in the same cycle: the segment at position 0 of the new filter is presented that cycle and consumed. The next position is (row 1, blk 0).
- Change while write=0: position resets to (0,0) for the new filter.
- Reset asserted mid-walk: position returns to (0,0) immediately and asynchronously.
- Last block: when OFM_SIZE is not a multiple of SYSTOLIC_SIZE, it reports the partial width (e.g. OFM_SIZE=13, SYSTOLIC_SIZE=16 gives size=13).
- Multiplies are by constants; the implementation may use shifts or adds.

Decomposition:
- Shared package contents:
  - Localparams NBLK, MAP_WORDS = OFM_SIZE*OFM_SIZE, and ROW_W/BLK_W counter widths via $clog2.
  - Function min_size(blk) returning the segment width.
- One natural sub-module, ofm_pos_counter: holds row/blk with enable (write), synchronous clear (chg) and wrap logic.
- Top level keeps prev_filter, change detect and address/size arithmetic.

Test Plan:
1. Default parameters, count_filter=0. Reset, then release -> ofm_addr=0, size=16. Assert rst_n mid-walk -> ofm_addr returns to 0 without waiting for a clock edge.
2. Five cycles of write=1 with filter 0 -> addresses 0,32,64,96,128 presented; ofm_addr=160 after.
3. write=0, count_filter set to 1 -> ofm_addr=1024 immediately and stays 1024 after the edge. Then 5 writes -> 1024,1056,...,1152; ofm_addr=1184 after.
4. Continuous write from (0,0) with filter 1:
   - write 32 -> ofm_addr=1040, size=16 (block 1).
   - write 63 -> ofm_addr=2032.
   - write 64 -> wraps to 1024.
5. count_filter 1->2 with write=1 at row 10 -> ofm_addr=2048 that cycle; next cycle 2080.
6. OFM_SIZE=13, SYSTOLIC_SIZE=16, filter 3 -> base 507, size=13. Write 13 segments -> back to 507, size=13 (single block).
